mul8_seq: RTL and testbench

MUL8_SEQ -- requirements
Module: mul8_seq

---
 rtl/mul8_pkg.sv | 13 +
 rtl/mul8_seq_adder8.sv | 22 ++
 rtl/mul8_seq.sv | 90 +++++++++
 tb/tb_mul8_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mul8_pkg.sv
// Shared types and constants for the 8x8 sequential shift-add multiplier.
package mul8_pkg;

    localparam int MUL_W    = 8;
    localparam int MUL_ITER = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul8_seq_adder8.sv
// 8-bit ripple-carry adder used as the single datapath adder of mul8_seq.
module adder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       c_in,
    output logic [7:0] sum,
    output logic       c_out
);

    logic carry;

    always_comb begin
        carry = c_in;
        sum   = '0;
        for (int i = 0; i < 8; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        c_out = carry;
    end

endmodule

// File: rtl/mul8_seq.sv
// Sequential 8x8 unsigned multiplier: one shift-add step per clock,
// valid/ready on both sides. States: IDLE accept | RUN iterate | DONE hold P.
module mul8_seq
    import mul8_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   A,
    input  logic [7:0]   B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [15:0]  P,
    output logic         busy
);

    state_t             state_q, state_d;
    logic [2:0]         count_q;
    logic [MUL_W-1:0]   mcand_q;
    logic [MUL_W-1:0]   upper_q;
    logic [MUL_W-1:0]   lower_q;
    logic [MUL_W-1:0]   addend;
    logic [MUL_W-1:0]   sum;
    logic               c_out;
    logic               accept;

    assign addend = lower_q[0] ? mcand_q : '0;

    adder8 u_adder (
        .a     (upper_q),
        .b     (addend),
        .c_in  (1'b0),
        .sum   (sum),
        .c_out (c_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (count_q == 3'(MUL_ITER - 1)) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    // The carry out of each step lands in upper[7] as the pair shifts right.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            mcand_q <= '0;
            upper_q <= '0;
            lower_q <= '0;
        end else if (accept) begin
            count_q <= '0;
            mcand_q <= A;
            upper_q <= '0;
            lower_q <= B;
        end else if (state_q == RUN) begin
            {upper_q, lower_q} <= {c_out, sum, lower_q[MUL_W-1:1]};
            count_q            <= count_q + 3'd1;
        end
    end

    assign P = {upper_q, lower_q};

endmodule

// File: tb/tb_mul8_seq.sv
// Scoreboard bench for mul8_seq: driver pushes expected products, monitor pops on handoff.
module tb_mul8_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  A = '0;
    logic [7:0]  B = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] P;
    logic        busy;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [15:0] exp_q[$];
    int          acc_q[$];
    logic [15:0] last_prod = '0;
    int          force_low = 0;
    bit          rand_ready = 0;
    bit          prev_valid = 0, prev_stall = 0, prev_hand = 0;

    mul8_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (P),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Waits for in_ready (optionally toggling junk operands meanwhile), then issues one pair.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit junk, output int acc_cyc);
        int n = 0;
        acc_cyc = -1;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            in_valid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            A = 8'($urandom);
            B = 8'($urandom);
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_ready_timeout: in_ready stuck low for %0d cycles", n);
            in_valid = 1'b0;
            return;
        end
        in_valid = 1'b1;
        A = a;
        B = b;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        exp_q.push_back(16'(a) * 16'(b));
        acc_q.push_back(cyc);
        in_valid = 1'b0;
        A = 8'($urandom);
        B = 8'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d products outstanding", exp_q.size());
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 0;
            prev_stall = 0;
            prev_hand  = 0;
        end else begin
            if (force_low > 0 && out_valid) begin
                out_ready = 1'b0;
                force_low--;
            end else if (rand_ready) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                out_ready = 1'b1;
            end
            chk("busy", busy, exp_q.size() != 0);
            if (prev_hand) begin
                chk("in_ready_after_handoff", in_ready, 1);
                chk("out_valid_after_handoff", out_valid, 0);
            end
            if (prev_stall) chk("out_valid_hold", out_valid, 1);
            if (out_valid) begin
                chk("in_ready_in_done", in_ready, 0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out_valid: P=0x%0h with no pending product", P);
                end else begin
                    if (!prev_valid) chk("latency", cyc - acc_q[0], 8);
                    chk("product", P, exp_q[0]);
                    if (out_ready) begin
                        last_prod = exp_q.pop_front();
                        void'(acc_q.pop_front());
                    end
                end
            end else if (in_ready) begin
                chk("P_idle_hold", P, last_prod);
            end
            prev_hand  = out_valid && out_ready;
            prev_stall = out_valid && !out_ready;
            prev_valid = out_valid;
        end
    end

    initial begin
        int acc;
        int deassert_cyc;

        #22;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_P", P, 16'h0000);
        @(posedge clk);
        #2 rst_n = 1'b1;

        run_op(8'd13, 8'd11, 0, acc);
        drain();
        chk("last_13x11", last_prod, 16'h008F);

        run_op(8'hFF, 8'hFF, 0, acc);
        run_op(8'h00, 8'h5A, 0, acc);
        run_op(8'h80, 8'h02, 0, acc);
        drain();

        force_low = 5;
        run_op(8'd200, 8'd37, 0, acc);
        drain();

        run_op(8'd3, 8'd4, 0, acc);
        @(negedge clk);
        in_valid = 1'b1;
        A = 8'h11;
        B = 8'h22;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        drain();
        chk("last_3x4", last_prod, 16'h000C);

        run_op(8'd5, 8'd6, 0, acc);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_P", P, 16'h0000);
        exp_q.delete();
        acc_q.delete();
        last_prod = '0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        deassert_cyc = cyc;
        run_op(8'd7, 8'd9, 0, acc);
        chk("accept_first_edge", acc - deassert_cyc, 1);
        drain();
        chk("last_7x9", last_prod, 16'h003F);

        rand_ready = 1;
        for (int i = 0; i < 2000; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), acc);
        end
        run_op(8'hFF, 8'hFF, 1, acc);
        run_op(8'h01, 8'hFF, 1, acc);
        run_op(8'hFF, 8'h00, 1, acc);
        drain();
        rand_ready = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
